// File: rtl/adpll_pkg.sv
// Shared widths, gain-state type and the saturating integrator adder for the
// ADPLL loop filter.
package adpll_pkg;

  localparam int PE_W   = 10;
  localparam int CTRL_W = 12;
  localparam int ACC_W  = 18;
  localparam int ERR_W  = PE_W + 1;
  // Sum path is wide enough to hold the integrator plus shifted error unclamped.
  localparam int SUM_W  = ACC_W + 2;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic                    clamped;
    logic signed [ACC_W-1:0] value;
  } sat_acc_t;

  function automatic sat_acc_t sat_add(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [ERR_W-1:0] err
  );
    logic signed [ACC_W:0] wide;
    sat_acc_t              res;
    wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - ERR_W){err[ERR_W-1]}}, err};
    res.clamped = 1'b0;
    res.value   = wide[ACC_W-1:0];
    // Top two bits disagree only when the true sum left the ACC_W range.
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      res.clamped = 1'b1;
      res.value   = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/adpll_lock_det.sv
// Lock detector: counts consecutive small-error samples to enter TRACK and
// drops back to ACQUIRE on any large error. gain_sel_o is the FSM state.
module adpll_lock_det
  import adpll_pkg::*;
#(
  parameter int LOCK_TOL   = 4,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_TOL = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [ERR_W-1:0] err_i,
  input  logic                    strobe_i,
  output logic                    locked_o,
  output lock_state_e             gain_sel_o
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] mag;

  // |err| fits unsigned in ERR_W bits, including the most negative value.
  assign mag = err_i[ERR_W-1] ? ERR_W'(-err_i) : ERR_W'(err_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (strobe_i) begin
      case (state_q)
        ACQUIRE: begin
          if (mag <= ERR_W'(LOCK_TOL)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(LOCK_CNT)) begin
              state_d = TRACK;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = '0;
          end
        end
        TRACK: begin
          if (mag > ERR_W'(UNLOCK_TOL)) begin
            state_d = ACQUIRE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ACQUIRE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACQUIRE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked_o   = (state_q == TRACK);
  assign gain_sel_o = state_q;

endmodule

// File: rtl/adpll_loop_filter.sv
// PI loop filter: TDC phase error in, DCO tuning word out, three register
// stages (capture, integrate, sum/clamp) with gains scheduled by lock state.
module adpll_loop_filter
  import adpll_pkg::*;
#(
  parameter int PHASE_TARGET = 512,
  parameter int DCO_MID      = 2048,
  parameter int KP_ACQ       = 4,
  parameter int KI_ACQ       = 4,
  parameter int KP_TRK       = 2,
  parameter int KI_TRK       = 8,
  parameter int LOCK_TOL     = 4,
  parameter int LOCK_CNT     = 16,
  parameter int UNLOCK_TOL   = 32
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic [PE_W-1:0]   phase_error,
  input  logic              pe_valid,
  input  logic              freeze,
  output logic [CTRL_W-1:0] dco_ctrl,
  output logic              ctrl_valid,
  output logic              locked,
  output logic              sat
);

  localparam logic signed [SUM_W-1:0] CTRL_MAX = SUM_W'((1 << CTRL_W) - 1);
  localparam logic signed [SUM_W-1:0] MID_W    = SUM_W'(DCO_MID);

  // Stage 0: captured sample.
  logic            s0_valid_q;
  logic [PE_W-1:0] s0_pe_q;

  // Stage 1: error, integrator and the gain chosen for this sample.
  logic                    s1_valid_q;
  logic signed [ERR_W-1:0] s1_err_q;
  lock_state_e             s1_gain_q;
  logic                    s1_iclamp_q;
  logic signed [ACC_W-1:0] integ_q;

  // Stage 2: outputs.
  logic [CTRL_W-1:0] dco_q;
  logic              ctrl_valid_q;
  logic              locked_q;
  logic              sat_q;

  logic signed [ERR_W-1:0] err_s0;
  sat_acc_t                integ_next;
  logic                    det_locked;
  lock_state_e             det_gain;

  logic signed [SUM_W-1:0] err_ext;
  logic signed [ACC_W-1:0] i_shift;
  logic signed [SUM_W-1:0] p_term;
  logic signed [SUM_W-1:0] i_term;
  logic signed [SUM_W-1:0] dco_sum;
  logic [CTRL_W-1:0]       dco_d;
  logic                    oclamp_d;

  assign err_s0     = $signed({1'b0, s0_pe_q}) - $signed(ERR_W'(PHASE_TARGET));
  assign integ_next = sat_add(integ_q, err_s0);

  adpll_lock_det #(
    .LOCK_TOL  (LOCK_TOL),
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_TOL(UNLOCK_TOL)
  ) u_lock_det (
    .clk       (ref_clk),
    .reset     (reset),
    .err_i     (err_s0),
    .strobe_i  (s0_valid_q),
    .locked_o  (det_locked),
    .gain_sel_o(det_gain)
  );

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
      s0_pe_q    <= '0;
    end else begin
      s0_valid_q <= pe_valid & ~freeze;
      if (pe_valid && !freeze) s0_pe_q <= phase_error;
    end
  end

  // The lock detector updates on this same edge, so det_gain here is still
  // the state that was current when this sample was accepted.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= '0;
      s1_gain_q   <= ACQUIRE;
      s1_iclamp_q <= 1'b0;
      integ_q     <= '0;
    end else begin
      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        s1_err_q    <= err_s0;
        s1_gain_q   <= det_gain;
        s1_iclamp_q <= integ_next.clamped;
        integ_q     <= integ_next.value;
      end
    end
  end

  always_comb begin
    err_ext = {{(SUM_W - ERR_W){s1_err_q[ERR_W-1]}}, s1_err_q};
    if (s1_gain_q == TRACK) begin
      p_term  = err_ext <<< KP_TRK;
      i_shift = integ_q >>> KI_TRK;
    end else begin
      p_term  = err_ext <<< KP_ACQ;
      i_shift = integ_q >>> KI_ACQ;
    end
    i_term  = {{(SUM_W - ACC_W){i_shift[ACC_W-1]}}, i_shift};
    dco_sum = MID_W + p_term + i_term;
    dco_d    = dco_sum[CTRL_W-1:0];
    oclamp_d = 1'b0;
    if (dco_sum[SUM_W-1]) begin
      dco_d    = '0;
      oclamp_d = 1'b1;
    end else if (dco_sum > CTRL_MAX) begin
      dco_d    = '1;
      oclamp_d = 1'b1;
    end
  end

  // locked is registered with the update so it reflects the state after
  // the sample whose tuning word is being presented.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      dco_q        <= CTRL_W'(DCO_MID);
      ctrl_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      ctrl_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        dco_q    <= dco_d;
        sat_q    <= oclamp_d | s1_iclamp_q;
        locked_q <= det_locked;
      end
    end
  end

  assign dco_ctrl   = dco_q;
  assign ctrl_valid = ctrl_valid_q;
  assign locked     = locked_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Bench for adpll_loop_filter: arithmetic reference model of the PI filter and
// lock rules, scoreboard on every update, plus directed scenario tasks.
module tb_adpll_loop_filter;

  logic        ref_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  phase_error = '0;
  logic        pe_valid = 1'b0;
  logic        freeze = 1'b0;
  logic [11:0] dco_ctrl;
  logic        ctrl_valid;
  logic        locked;
  logic        sat;

  adpll_loop_filter dut (
    .ref_clk    (ref_clk),
    .reset      (reset),
    .phase_error(phase_error),
    .pe_valid   (pe_valid),
    .freeze     (freeze),
    .dco_ctrl   (dco_ctrl),
    .ctrl_valid (ctrl_valid),
    .locked     (locked),
    .sat        (sat)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct packed {
    logic [31:0] due;
    logic [11:0] dco;
    logic        sat;
    logic        locked;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic mon_locked = 1'b0;

  // Reference model state
  int m_integ = 0;
  int m_cnt = 0;
  bit m_locked = 1'b0;
  int m_last_dco = 2048;

  function automatic int floor_div(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  task automatic model_reset();
    m_integ    = 0;
    m_cnt      = 0;
    m_locked   = 1'b0;
    m_last_dco = 2048;
    mon_locked = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_sample(input int pe);
    int   err, mag, kp_mul, ki_div, t, sum;
    bit   iclamp, oclamp;
    exp_t e;
    err    = pe - 512;
    kp_mul = m_locked ? 4 : 16;
    ki_div = m_locked ? 256 : 16;
    t      = m_integ + err;
    iclamp = 1'b0;
    if (t > 131071) begin t = 131071; iclamp = 1'b1; end
    if (t < -131072) begin t = -131072; iclamp = 1'b1; end
    m_integ = t;
    sum     = 2048 + err * kp_mul + floor_div(m_integ, ki_div);
    oclamp  = 1'b0;
    if (sum < 0) begin sum = 0; oclamp = 1'b1; end
    if (sum > 4095) begin sum = 4095; oclamp = 1'b1; end
    m_last_dco = sum;
    mag = (err < 0) ? -err : err;
    if (!m_locked) begin
      if (mag <= 4) begin
        m_cnt++;
        if (m_cnt == 16) begin m_locked = 1'b1; m_cnt = 0; end
      end else begin
        m_cnt = 0;
      end
    end else if (mag > 32) begin
      m_locked = 1'b0;
      m_cnt    = 0;
    end
    e.due    = 32'(cyc + 2);
    e.dco    = 12'(sum);
    e.sat    = iclamp | oclamp;
    e.locked = m_locked;
    exp_q.push_back(e);
  endtask

  // Driver: one clock per call; inputs change 1 time unit after the edge.
  task automatic step(input logic v, input logic [9:0] pe, input logic frz);
    pe_valid    = v;
    phase_error = pe;
    freeze      = frz;
    @(posedge ref_clk);
    cyc++;
    if (reset) model_reset();
    else if (v && !frz) model_sample(int'(pe));
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 1'b0);
    reset = 1'b0;
  endtask

  // Scoreboard: every negedge either an expected update is due or nothing is.
  always @(negedge ref_clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && int'(exp_q[0].due) == cyc) begin
        mon_e = exp_q.pop_front();
        total++;
        if (ctrl_valid !== 1'b1) begin
          bad++; $display("FAIL upd_valid cyc=%0d got=%b exp=1", cyc, ctrl_valid);
        end
        total++;
        if (dco_ctrl !== mon_e.dco) begin
          bad++; $display("FAIL upd_dco cyc=%0d got=%0d exp=%0d", cyc, dco_ctrl, mon_e.dco);
        end
        total++;
        if (sat !== mon_e.sat) begin
          bad++; $display("FAIL upd_sat cyc=%0d got=%b exp=%b", cyc, sat, mon_e.sat);
        end
        mon_locked = mon_e.locked;
      end else begin
        total++;
        if (ctrl_valid !== 1'b0) begin
          bad++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", cyc, ctrl_valid);
        end
      end
      total++;
      if (locked !== mon_locked) begin
        bad++; $display("FAIL locked cyc=%0d got=%b exp=%b", cyc, locked, mon_locked);
      end
    end
  end

  task automatic test_reset();
    do_reset(2);
    mon_en = 1'b1;
    total++; if (dco_ctrl !== 12'd2048) begin bad++; $display("FAIL rst_dco got=%0d exp=2048", dco_ctrl); end
    total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ctrl_valid); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b exp=0", locked); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL rst_sat got=%b exp=0", sat); end
  endtask

  task automatic test_lock_at_target();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 10'd512, 1'b0);
      // Sample 16 (index 15) is accepted at i==15; its update shows after i==17.
      if (i == 16) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%b exp=0", locked); end
      end
      if (i == 17) begin
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_rise got=%b exp=1", locked); end
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 10'd0, 1'b0);
    total++; if (dco_ctrl !== 12'd2048) begin bad++; $display("FAIL lock_dco got=%0d exp=2048", dco_ctrl); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL lock_sat got=%b exp=0", sat); end
  endtask

  task automatic test_single_520();
    do_reset(1);
    step(1'b1, 10'd520, 1'b0);
    step(1'b0, 10'd0, 1'b0);
    total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL s520_early got=%b exp=0", ctrl_valid); end
    step(1'b0, 10'd0, 1'b0);
    total++; if (ctrl_valid !== 1'b1) begin bad++; $display("FAIL s520_valid got=%b exp=1", ctrl_valid); end
    total++; if (dco_ctrl !== 12'd2176) begin bad++; $display("FAIL s520_dco got=%0d exp=2176", dco_ctrl); end
    step(1'b0, 10'd0, 1'b0);
    total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL s520_pulse got=%b exp=0", ctrl_valid); end
  endtask

  task automatic test_saturation();
    do_reset(1);
    for (int i = 0; i < 257; i++) begin
      step(1'b1, 10'd1023, 1'b0);
      if (i == 2) begin
        total++; if (dco_ctrl !== 12'd4095) begin bad++; $display("FAIL sat_dco got=%0d exp=4095", dco_ctrl); end
        total++; if (sat !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b exp=1", sat); end
      end
    end
    total++;
    if (dut.integ_q !== 18'sd130816) begin
      bad++; $display("FAIL integ_256 got=%0d exp=130816", dut.integ_q);
    end
    step(1'b0, 10'd0, 1'b0);
    total++;
    if (dut.integ_q !== 18'sd131071) begin
      bad++; $display("FAIL integ_clamp got=%0d exp=131071", dut.integ_q);
    end
    step(1'b0, 10'd0, 1'b0);
    total++; if (sat !== 1'b1) begin bad++; $display("FAIL sat_hold got=%b exp=1", sat); end
  endtask

  task automatic test_unlock();
    do_reset(1);
    for (int i = 0; i < 16; i++) step(1'b1, 10'd512, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 10'd0, 1'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL unl_pre got=%b exp=1", locked); end
    step(1'b1, 10'd560, 1'b0);
    step(1'b1, 10'd520, 1'b0);
    step(1'b0, 10'd0, 1'b0);
    total++; if (dco_ctrl !== 12'd2240) begin bad++; $display("FAIL unl_trk_dco got=%0d exp=2240", dco_ctrl); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL unl_drop got=%b exp=0", locked); end
    step(1'b0, 10'd0, 1'b0);
    total++; if (dco_ctrl !== 12'd2179) begin bad++; $display("FAIL unl_acq_dco got=%0d exp=2179", dco_ctrl); end
  endtask

  task automatic test_freeze();
    do_reset(1);
    step(1'b1, 10'd530, 1'b0);
    step(1'b1, 10'd495, 1'b0);
    step(1'b1, 10'd540, 1'b0);
    step(1'b1, 10'd520, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 10'($urandom_range(0, 1023)), 1'b1);
    step(1'b0, 10'd0, 1'b1);
    total++;
    if (dco_ctrl !== 12'(m_last_dco)) begin
      bad++; $display("FAIL frz_dco got=%0d exp=%0d", dco_ctrl, m_last_dco);
    end
    total++;
    if (dut.integ_q !== 18'(m_integ)) begin
      bad++; $display("FAIL frz_integ got=%0d exp=%0d", dut.integ_q, m_integ);
    end
    step(1'b1, 10'd500, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 10'd0, 1'b0);
    total++;
    if (dco_ctrl !== 12'(m_last_dco)) begin
      bad++; $display("FAIL frz_resume got=%0d exp=%0d", dco_ctrl, m_last_dco);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset(1);
    for (int i = 0; i < 16; i++) step(1'b1, 10'd512, 1'b0);
    step(1'b1, 10'd600, 1'b0);
    step(1'b1, 10'd700, 1'b0);
    reset = 1'b1;
    step(1'b1, 10'd800, 1'b0);
    reset = 1'b0;
    total++; if (dco_ctrl !== 12'd2048) begin bad++; $display("FAIL mid_dco got=%0d exp=2048", dco_ctrl); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_locked got=%b exp=0", locked); end
    total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", ctrl_valid); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL mid_sat got=%b exp=0", sat); end
    for (int i = 0; i < 4; i++) step(1'b0, 10'd0, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    int   sel;
    logic [9:0] pe;
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 16) pe = 10'($urandom_range(509, 515));
      else if (sel < 19) pe = 10'($urandom_range(470, 554));
      else pe = 10'($urandom_range(0, 1023));
      step(($urandom_range(0, 3) != 0), pe, ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 10'd0, 1'b0);
    total++;
    if (dco_ctrl !== 12'(m_last_dco)) begin
      bad++; $display("FAIL rnd_dco got=%0d exp=%0d", dco_ctrl, m_last_dco);
    end
    total++;
    if (locked !== m_locked) begin
      bad++; $display("FAIL rnd_locked got=%b exp=%b", locked, m_locked);
    end
  endtask

  initial begin
    test_reset();
    test_lock_at_target();
    test_single_520();
    test_saturation();
    test_unlock();
    test_freeze();
    test_reset_midstream();
    test_back_to_back_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
